// File: rtl/button_conditioner.sv
// Multi-channel push-button conditioner: synchroniser, debouncer, press/release
// pulses, optional hold-to-repeat and a registered chord detector.
module button_conditioner #(
  parameter int CHANNELS = 4,
  parameter int SYNC_STAGES = 3,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int REPEAT_DELAY = 15000000,
  parameter int REPEAT_PERIOD = 5000000,
  parameter logic [CHANNELS-1:0] REPEAT_MASK = '0,
  parameter logic [CHANNELS-1:0] CHORD_MASK = '0
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [CHANNELS-1:0] in,
  output logic [CHANNELS-1:0] level,
  output logic [CHANNELS-1:0] press,
  output logic [CHANNELS-1:0] release_pulse,
  output logic [CHANNELS-1:0] repeat_pulse,
  output logic [CHANNELS-1:0] action,
  output logic                chord
);

  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ?
                        REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RW = $clog2(RMAX + 1);

  localparam logic [DW-1:0] DB_MAX = DW'(DEBOUNCE_CYCLES);
  localparam logic [RW-1:0] RD_LAST = RW'(REPEAT_DELAY - 1);
  localparam logic [RW-1:0] RP_LAST = RW'(REPEAT_PERIOD - 1);

  typedef enum logic [1:0] {
    IDLE,
    DELAY,
    RPT
  } rstate_t;

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    logic [SYNC_STAGES-1:0] sync;
    logic [DW-1:0] dcnt;
    logic lvl;
    logic prs;
    logic rel;
    logic rpt;
    logic accept;
    logic rise;
    logic fall;

    // accept fires one edge after the difference has persisted long enough
    assign accept = (dcnt == DB_MAX);
    assign rise = accept & ~lvl;
    assign fall = accept & lvl;

    always_ff @(posedge clk) begin
      if (reset) begin
        sync <= '0;
        dcnt <= '0;
        lvl <= 1'b0;
        prs <= 1'b0;
        rel <= 1'b0;
      end else begin
        sync <= {sync[SYNC_STAGES-2:0], in[i]};
        prs <= rise;
        rel <= fall;
        if (accept) begin
          lvl <= ~lvl;
          dcnt <= '0;
        end else if (sync[SYNC_STAGES-1] != lvl) begin
          dcnt <= dcnt + DW'(1);
        end else begin
          dcnt <= '0;
        end
      end
    end

    if (REPEAT_MASK[i]) begin : g_rpt
      rstate_t state;
      logic [RW-1:0] rcnt;

      always_ff @(posedge clk) begin
        if (reset) begin
          state <= IDLE;
          rcnt <= '0;
          rpt <= 1'b0;
        end else begin
          rpt <= 1'b0;
          if (rise) begin
            state <= DELAY;
            rcnt <= '0;
          end else if (fall || !lvl) begin
            // a falling edge kills any repeat due in the same cycle
            state <= IDLE;
            rcnt <= '0;
          end else begin
            unique case (state)
              DELAY: begin
                if (rcnt == RD_LAST) begin
                  rpt <= 1'b1;
                  state <= RPT;
                  rcnt <= '0;
                end else begin
                  rcnt <= rcnt + RW'(1);
                end
              end
              RPT: begin
                if (rcnt == RP_LAST) begin
                  rpt <= 1'b1;
                  rcnt <= '0;
                end else begin
                  rcnt <= rcnt + RW'(1);
                end
              end
              default: rcnt <= '0;
            endcase
          end
        end
      end
    end else begin : g_norpt
      assign rpt = 1'b0;
    end

    assign level[i] = lvl;
    assign press[i] = prs;
    assign release_pulse[i] = rel;
    assign repeat_pulse[i] = rpt;
  end

  assign action = press | repeat_pulse;

  logic held;
  logic held_r;

  assign held = (CHORD_MASK != '0) &&
                ((level & CHORD_MASK) == CHORD_MASK);

  always_ff @(posedge clk) begin
    if (reset) begin
      held_r <= 1'b0;
      chord <= 1'b0;
    end else begin
      held_r <= held;
      chord <= held & ~held_r;
    end
  end

endmodule

// File: tb/tb_button_conditioner.sv
// Directed bench for button_conditioner; expected pulses are queued as events
// and every cycle's outputs are compared against the due events.
module tb_button_conditioner;

  localparam int LAT = 6;
  localparam int RD = 10;
  localparam int RP = 3;

  localparam int K_PRESS = 0;
  localparam int K_REL = 1;
  localparam int K_RPT = 2;
  localparam int K_CHORD = 3;

  typedef struct {
    int cyc;
    int kind;
    int ch;
  } ev_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [1:0] in_v = 2'b00;
  logic [1:0] level, press, release_pulse, repeat_pulse, action;
  logic chord;

  ev_t sb[$];
  logic [1:0] exp_level = 2'b00;
  int cyc = 0;
  int checks = 0;
  int errors = 0;

  button_conditioner #(
    .CHANNELS(2),
    .SYNC_STAGES(2),
    .DEBOUNCE_CYCLES(4),
    .REPEAT_DELAY(RD),
    .REPEAT_PERIOD(RP),
    .REPEAT_MASK(2'b10),
    .CHORD_MASK(2'b11)
  ) dut (
    .clk(clk),
    .reset(reset),
    .in(in_v),
    .level(level),
    .press(press),
    .release_pulse(release_pulse),
    .repeat_pulse(repeat_pulse),
    .action(action),
    .chord(chord)
  );

  always #5 clk = ~clk;

  task automatic push(input int c, input int k, input int ch);
    ev_t e;
    e.cyc = c;
    e.kind = k;
    e.ch = ch;
    sb.push_back(e);
  endtask

  // repeats for a channel pressed at edge t whose level falls at edge f
  task automatic push_repeats(input int t, input int f, input int ch);
    for (int r = t + RD; r < f; r += RP) push(r, K_RPT, ch);
  endtask

  task automatic check();
    logic [1:0] ep, er, et;
    logic ec;
    logic [10:0] got, exp;
    ep = '0;
    er = '0;
    et = '0;
    ec = 1'b0;
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].cyc == cyc) begin
        case (sb[i].kind)
          K_PRESS: begin
            ep[sb[i].ch] = 1'b1;
            exp_level[sb[i].ch] = 1'b1;
          end
          K_REL: begin
            er[sb[i].ch] = 1'b1;
            exp_level[sb[i].ch] = 1'b0;
          end
          K_RPT: et[sb[i].ch] = 1'b1;
          default: ec = 1'b1;
        endcase
        sb.delete(i);
      end
    end
    got = {level, press, release_pulse, repeat_pulse, action, chord};
    exp = {exp_level, ep, er, et, ep | et, ec};
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL outputs cyc=%0d got=%b exp=%b (lvl,prs,rel,rpt,act,chord)",
             cyc, got, exp);
    end
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      cyc++;
      #1;
      check();
    end
  endtask

  initial begin
    int s, s1, t, f, r;

    // reset: everything low
    tick(3);
    reset = 1'b0;
    tick(2);

    // clean press/release on channel 0
    s = cyc + 1;
    in_v[0] = 1'b1;
    push(s + LAT, K_PRESS, 0);
    tick(12);
    s = cyc + 1;
    in_v[0] = 1'b0;
    push(s + LAT, K_REL, 0);
    tick(10);

    // 3-cycle glitch is rejected
    in_v[0] = 1'b1;
    tick(3);
    in_v[0] = 1'b0;
    tick(10);

    // 4-cycle pulse is accepted; the low level only starts to count
    // once level has risen, so release lands 5 edges after the press
    s = cyc + 1;
    in_v[0] = 1'b1;
    push(s + LAT, K_PRESS, 0);
    tick(4);
    push(s + LAT + 5, K_REL, 0);
    in_v[0] = 1'b0;
    tick(14);

    // auto-repeat on channel 1, released as a repeat falls due
    s = cyc + 1;
    t = s + LAT;
    f = s + 40 + LAT;
    in_v[1] = 1'b1;
    push(t, K_PRESS, 1);
    push_repeats(t, f, 1);
    push(f, K_REL, 1);
    tick(40);
    in_v[1] = 1'b0;
    tick(12);

    // chord: ch0 then ch1 20 cycles later; ch0 bounce re-arms it
    s = cyc + 1;
    in_v[0] = 1'b1;
    push(s + LAT, K_PRESS, 0);
    tick(20);
    s1 = cyc + 1;
    t = s1 + LAT;
    f = s1 + 42 + LAT;
    in_v[1] = 1'b1;
    push(t, K_PRESS, 1);
    push(t + 1, K_CHORD, 0);
    push_repeats(t, f, 1);
    push(f, K_REL, 1);
    tick(15);
    r = cyc + 1;
    in_v[0] = 1'b0;
    push(r + LAT, K_REL, 0);
    tick(12);
    r = cyc + 1;
    in_v[0] = 1'b1;
    push(r + LAT, K_PRESS, 0);
    push(r + LAT + 1, K_CHORD, 0);
    tick(15);
    r = cyc + 1;
    in_v = 2'b00;
    push(r + LAT, K_REL, 0);
    tick(12);

    // reset while channel 1 is repeating
    s = cyc + 1;
    t = s + LAT;
    in_v[1] = 1'b1;
    push(t, K_PRESS, 1);
    push_repeats(t, t + 40, 1);
    tick(20);
    reset = 1'b1;
    sb.delete();
    exp_level = 2'b00;
    tick(2);
    reset = 1'b0;
    s = cyc + 1;
    t = s + LAT;
    f = s + 25 + LAT;
    push(t, K_PRESS, 1);
    push_repeats(t, f, 1);
    push(f, K_REL, 1);
    tick(25);
    in_v[1] = 1'b0;
    tick(12);

    // simultaneous press on both channels
    s = cyc + 1;
    t = s + LAT;
    f = s + 15 + LAT;
    in_v = 2'b11;
    push(t, K_PRESS, 0);
    push(t, K_PRESS, 1);
    push(t + 1, K_CHORD, 0);
    push_repeats(t, f, 1);
    push(f, K_REL, 0);
    push(f, K_REL, 1);
    tick(15);
    in_v = 2'b00;
    tick(12);

    checks++;
    assert (sb.size() == 0) else begin
      errors++;
      $error("FAIL pending_events got=%0d exp=0", sb.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/button_conditioner.md
Name: button_conditioner

Overview:
Multi-channel input conditioner for the board's push-buttons and other slow asynchronous level inputs. It generalises the fixed synchroniser and edge-pulse pair with:
- a configurable synchroniser depth;
- per-channel debouncing;
- press and release pulses;
- optional per-channel hold-to-repeat;
- a chord detector for multi-button commands such as restart.

It sits between raw `btn` pins and game-control logic, one instance per button bank.

Parameters:
CHANNELS, 4, number of independent input channels
SYNC_STAGES, 3, synchroniser flop depth (>=2)
DEBOUNCE_CYCLES, 500000, consecutive cycles a new synchronised level must persist before acceptance (>=1; 10 ms at 50 MHz)
REPEAT_DELAY, 15000000, cycles from press to first repeat pulse (>=1)
REPEAT_PERIOD, 5000000, cycles between subsequent repeat pulses (>=1)
REPEAT_MASK, 0, CHANNELS-bit; bit i=1 enables auto-repeat on channel i
CHORD_MASK, 0, CHANNELS-bit; set of channels forming the chord; 0 disables chord

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
in  in  CHANNELS  raw asynchronous inputs, active-high
level  out  CHANNELS  debounced level per channel
press  out  CHANNELS  one-cycle pulse on accepted 0->1 transition
release  out  CHANNELS  one-cycle pulse on accepted 1->0 transition
repeat  out  CHANNELS  one-cycle auto-repeat pulse
action  out  CHANNELS  press | repeat, per channel
chord  out  1  one-cycle pulse when all CHORD_MASK channels become simultaneously held

Behaviour:
- Reset: all synchroniser flops, counters, FSMs and outputs are 0. Reset mid-operation aborts any debounce or repeat in progress with no pulse. An input held through reset is reported as a fresh press after the full latency.
- Synchroniser: SYNC_STAGES flops per channel. The last stage is the debouncer input.
- Debounce, per channel:
  - Counter of width $clog2(DEBOUNCE_CYCLES+1).
  - When the sync output equals `level`, the counter clears.
  - When it differs, the counter increments.
  - On the cycle the difference has persisted DEBOUNCE_CYCLES consecutive cycles, `level` toggles and the counter clears.
  - A glitch shorter than DEBOUNCE_CYCLES produces no output change.
- Latency: a clean input step seen at clock edge 0 makes `level` change, and `press` or `release` pulse, at edge SYNC_STAGES+DEBOUNCE_CYCLES.
- Press/release pulses are registered and coincident with the `level` change, one cycle wide.
- Repeat FSM, per channel. Channels with a 0 in REPEAT_MASK hold IDLE and `repeat` stays 0.
  - IDLE: on `press`, go to DELAY with the counter at 0.
  - DELAY: while `level`=1, count. After REPEAT_DELAY cycles in DELAY, pulse `repeat` and go to REPEAT with the counter at 0.
  - REPEAT: while `level`=1, pulse `repeat` every REPEAT_PERIOD cycles.
  - Any state: `level`=0 returns the FSM to IDLE immediately. No `repeat` pulse occurs in or after the cycle `level` falls.
  - First repeat comes REPEAT_DELAY cycles after `press`; subsequent repeats are spaced REPEAT_PERIOD cycles apart.
  - `press` and `repeat` are never high in the same cycle, so `action` is a single pulse per event.
- Repeat counter: width covers max(REPEAT_DELAY, REPEAT_PERIOD). No wrap while held; it reloads on each pulse.
- Chord:
  - held = (level & CHORD_MASK) == CHORD_MASK, with CHORD_MASK != 0.
  - `chord` pulses one cycle on the cycle held goes 0->1, and does not re-fire until held drops.
  - Channel `press` pulses are still emitted for chord members.
  - If chord members are accepted in the same cycle, `chord` fires one cycle after those presses (held is registered from `level`).
- Channels are fully independent. Simultaneous events on several channels each produce their own pulses in the same cycle.

Test Plan:
Bench parameters: CHANNELS=2, SYNC_STAGES=2, DEBOUNCE_CYCLES=4, REPEAT_DELAY=10, REPEAT_PERIOD=3, REPEAT_MASK=2'b10, CHORD_MASK=2'b11.
- Clean press: in[0] 0->1 at edge 0 and held -> level[0] and press[0] high at edge 6, press[0] one cycle only; no repeat[0] ever. Releasing -> release[0] one cycle, 6 edges after the release.
- Glitch rejection: in[0] high for 3 cycles then low -> level, press and release stay 0. A 4-cycle high pulse (post-sync) -> accepted.
- Auto-repeat: hold in[1] 40 cycles -> press[1] at T; repeat[1] at T+10, T+13, T+16, …; action[1] equals their union. Releasing just before a due repeat -> no further repeat.
- Chord: press in[0], then in[1] 20 cycles later -> chord one cycle, 1 cycle after press[1]. Releasing in[0] and re-pressing it -> chord fires again. Holding both -> no second chord.
- Reset mid-repeat: assert reset during REPEAT -> all outputs 0 next cycle. With in[1] still held, after deasserting reset -> press[1] at 6 edges, then repeats restart from the DELAY timing.
- Simultaneous: both inputs step together -> press[0] and press[1] in the same cycle, chord one cycle later.
